// File: rtl/otn_tx_frame_sched_if.sv
// ---------------------------------------------------------------------------
// otn_tx_frame_sched_if
//
// Bundles the scheduler's data-path signals: the overhead lookup port, the
// payload stream handshake and the line-side output with its position
// qualifiers. Clock and reset are kept as plain ports on the scheduler.
//
// Signals:
//   i_enable            start/continue framing (sampled at frame boundary)
//   i_line_retrans_req  downstream hold request
//   o_oh_row, o_oh_col  position of the overhead byte being requested
//   i_oh_data           overhead byte for o_oh_row/o_oh_col, same cycle
//   i_pl_data           payload byte
//   i_pl_valid          payload byte available
//   o_pl_ready          scheduler takes the payload byte this cycle
//   o_data, o_valid     registered line byte and its qualifier
//   o_row_cnt           row of the byte on o_data
//   o_col_cnt           column of the byte on o_data
//   o_sof               marks the row 0 / column 0 byte
//   o_stall_cnt         saturating count of payload-underrun cycles
//
// Modports:
//   master  scheduler side (drives the o_* signals)
//   slave   environment side (drives the i_* signals)
// ---------------------------------------------------------------------------
interface otn_tx_frame_sched_if;
    logic        i_enable;
    logic        i_line_retrans_req;
    logic [1:0]  o_oh_row;
    logic [3:0]  o_oh_col;
    logic [7:0]  i_oh_data;
    logic [7:0]  i_pl_data;
    logic        i_pl_valid;
    logic        o_pl_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic [1:0]  o_row_cnt;
    logic [10:0] o_col_cnt;
    logic        o_sof;
    logic [15:0] o_stall_cnt;

    modport master (
        input  i_enable,
        input  i_line_retrans_req,
        output o_oh_row,
        output o_oh_col,
        input  i_oh_data,
        input  i_pl_data,
        input  i_pl_valid,
        output o_pl_ready,
        output o_data,
        output o_valid,
        output o_row_cnt,
        output o_col_cnt,
        output o_sof,
        output o_stall_cnt
    );

    modport slave (
        output i_enable,
        output i_line_retrans_req,
        input  o_oh_row,
        input  o_oh_col,
        output i_oh_data,
        output i_pl_data,
        output i_pl_valid,
        input  o_pl_ready,
        input  o_data,
        input  o_valid,
        input  o_row_cnt,
        input  o_col_cnt,
        input  o_sof,
        input  o_stall_cnt
    );
endinterface

// File: rtl/otn_tx_frame_sched.sv
// ---------------------------------------------------------------------------
// otn_tx_frame_sched
//
// Transmit-side scheduler for a NUM_ROWS x ROW_COLS line frame. For every
// column it picks the byte source: overhead lookup (columns 0..OH_COLS-1),
// payload stream (columns OH_COLS..ROW_COLS-2) or the row parity byte
// (column ROW_COLS-1, XOR of all payload bytes of the row). The frame
// position only moves when a byte is actually emitted, so payload underrun
// and downstream retransmission requests stall the frame in place.
//
// Ports:
//   i_clk  clock
//   i_rst  synchronous, active-high reset
//   bus    otn_tx_frame_sched_if.master (overhead port, payload handshake,
//          registered line output, position qualifiers, stall counter)
//
// Timing: the byte selected in cycle N appears on o_data/o_valid with its
// row/column in cycle N+1. o_oh_row/o_oh_col and o_pl_ready are
// combinational from the current state and position.
// ---------------------------------------------------------------------------
module otn_tx_frame_sched #(
    parameter int OH_COLS  = 16,
    parameter int ROW_COLS = 1041,
    parameter int NUM_ROWS = 4
) (
    input logic                   i_clk,
    input logic                   i_rst,
    otn_tx_frame_sched_if.master  bus
);

    localparam logic [10:0] LAST_OH_COL = 11'(OH_COLS - 1);
    localparam logic [10:0] LAST_PL_COL = 11'(ROW_COLS - 2);
    localparam logic [10:0] PARITY_COL  = 11'(ROW_COLS - 1);
    localparam logic [1:0]  LAST_ROW    = 2'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        OH,
        PAYLOAD,
        PARITY
    } state_t;

    state_t      state;
    logic [1:0]  row_pos;
    logic [10:0] col_pos;
    logic [7:0]  parity_acc;

    logic [7:0]  data_q;
    logic        valid_q;
    logic [1:0]  row_q;
    logic [10:0] col_q;
    logic        sof_q;
    logic [15:0] stall_q;

    logic        hold;
    logic        pl_accept;

    // Retransmission freezes everything except the IDLE->OH start decision.
    assign hold      = bus.i_line_retrans_req;
    assign pl_accept = bus.i_pl_valid && bus.o_pl_ready;

    // The overhead generator is addressed with the next position to be sent.
    assign bus.o_oh_row   = row_pos;
    assign bus.o_oh_col   = col_pos[3:0];
    assign bus.o_pl_ready = (state == PAYLOAD) && !hold;

    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_row_cnt   = row_q;
    assign bus.o_col_cnt   = col_q;
    assign bus.o_sof       = sof_q;
    assign bus.o_stall_cnt = stall_q;

    // Frame FSM plus all registered outputs. valid/sof default low each
    // cycle; position and data registers keep the last emitted values so
    // the downstream counter can hold while o_valid is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            row_pos    <= '0;
            col_pos    <= '0;
            parity_acc <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            sof_q      <= 1'b0;
            stall_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_enable) begin
                        state      <= OH;
                        row_pos    <= '0;
                        col_pos    <= '0;
                        parity_acc <= '0;
                    end
                end

                OH: begin
                    if (!hold) begin
                        data_q  <= bus.i_oh_data;
                        valid_q <= 1'b1;
                        row_q   <= row_pos;
                        col_q   <= col_pos;
                        sof_q   <= (row_pos == 2'd0) && (col_pos == 11'd0);
                        col_pos <= col_pos + 11'd1;
                        if (col_pos == LAST_OH_COL) begin
                            state <= PAYLOAD;
                        end
                    end
                end

                PAYLOAD: begin
                    if (pl_accept) begin
                        data_q     <= bus.i_pl_data;
                        valid_q    <= 1'b1;
                        row_q      <= row_pos;
                        col_q      <= col_pos;
                        parity_acc <= parity_acc ^ bus.i_pl_data;
                        col_pos    <= col_pos + 11'd1;
                        if (col_pos == LAST_PL_COL) begin
                            state <= PARITY;
                        end
                    end else if (!hold && (stall_q != 16'hFFFF)) begin
                        // Underrun only counts when retrans is not already holding us.
                        stall_q <= stall_q + 16'd1;
                    end
                end

                PARITY: begin
                    if (!hold) begin
                        // The accumulator already includes the last payload byte,
                        // so it is the full-row XOR; clear it for the next row.
                        data_q     <= parity_acc;
                        valid_q    <= 1'b1;
                        row_q      <= row_pos;
                        col_q      <= PARITY_COL;
                        parity_acc <= '0;
                        col_pos    <= '0;
                        if (row_pos == LAST_ROW) begin
                            row_pos <= '0;
                            state   <= bus.i_enable ? OH : IDLE;
                        end else begin
                            row_pos <= row_pos + 2'd1;
                            state   <= OH;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otn_tx_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_otn_tx_frame_sched
//
// Scoreboard bench for otn_tx_frame_sched. The stimulus side pre-loads a
// payload buffer and pushes the expected line byte sequence (data, row,
// column, sof) for every frame it launches; an independent monitor pops and
// compares each time the scheduler presents o_valid. Directed checks cover
// reset values, underrun, retransmission in overhead, retrans/underrun
// overlap, parity, enable deassertion and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_otn_tx_frame_sched;

    localparam int WAIT_LIMIT = 20000;

    typedef struct packed {
        logic [7:0]  data;
        logic [1:0]  row;
        logic [10:0] col;
        logic        sof;
    } exp_t;

    logic i_clk;
    logic i_rst;

    otn_tx_frame_sched_if bus();

    otn_tx_frame_sched dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int sof_count = 0;
    int sof_t [2];

    exp_t        exp_q [$];
    logic [7:0]  pl_mem [0:65535];
    logic [15:0] pl_wr  = '0;
    logic [15:0] pl_rd  = '0;
    logic [7:0]  inc_val = '0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Overhead generator model: byte = 0xA0 | requested column.
    assign bus.i_oh_data = 8'hA0 | {4'h0, bus.o_oh_col};
    // Payload source presents the next unread buffered byte.
    assign bus.i_pl_data = pl_mem[pl_rd];

    // Payload source pops a byte on every handshake.
    always @(posedge i_clk) begin
        if (bus.i_pl_valid && bus.o_pl_ready) begin
            pl_rd <= pl_rd + 16'd1;
        end
    end

    // Monitor: compare every presented byte against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            cycle++;
            if (!i_rst && bus.o_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_output actual data=0x%0h row=%0d col=%0d required no output",
                             bus.o_data, bus.o_row_cnt, bus.o_col_cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.o_data !== e.data || bus.o_row_cnt !== e.row ||
                        bus.o_col_cnt !== e.col || bus.o_sof !== e.sof) begin
                        failures++;
                        $display("[TB] FAIL scoreboard actual data=0x%0h row=%0d col=%0d sof=%0b required data=0x%0h row=%0d col=%0d sof=%0b",
                                 bus.o_data, bus.o_row_cnt, bus.o_col_cnt, bus.o_sof,
                                 e.data, e.row, e.col, e.sof);
                    end
                end
                if (bus.o_sof) begin
                    if (sof_count < 2) sof_t[sof_count] = cycle;
                    sof_count++;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic enable, input logic pl_valid, input logic retrans);
        bus.i_enable           = enable;
        bus.i_pl_valid         = pl_valid;
        bus.i_line_retrans_req = retrans;
    endtask

    // Loads one frame of payload and its expected line sequence. When
    // pattern_row0 is set, row 0 carries zeros except 0x5A at col 20 and
    // 0x0F at col 900; everything else is an incrementing byte stream.
    task automatic pushFrame(input bit pattern_row0);
        logic [7:0] b;
        logic [7:0] par;
        for (int r = 0; r < 4; r++) begin
            par = 8'h00;
            for (int c = 0; c < 16; c++) begin
                exp_q.push_back('{8'hA0 | 8'(c), 2'(r), 11'(c), 1'((r == 0) && (c == 0))});
            end
            for (int c = 16; c < 1040; c++) begin
                if (pattern_row0 && r == 0) begin
                    b = (c == 20) ? 8'h5A : ((c == 900) ? 8'h0F : 8'h00);
                end else begin
                    b = inc_val;
                    inc_val = inc_val + 8'd1;
                end
                pl_mem[pl_wr] = b;
                pl_wr = pl_wr + 16'd1;
                exp_q.push_back('{b, 2'(r), 11'(c), 1'b0});
                par = par ^ b;
            end
            exp_q.push_back('{par, 2'(r), 11'd1040, 1'b0});
        end
    endtask

    // Bounded wait for the DUT to present a given position.
    task automatic waitPos(input int r, input int c, input string name);
        bit found = 0;
        for (int n = 0; n < WAIT_LIMIT && !found; n++) begin
            @(negedge i_clk);
            if (bus.o_valid && bus.o_row_cnt == 2'(r) && bus.o_col_cnt == 11'(c)) found = 1;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout_%s actual=not_seen required=row%0d_col%0d", name, r, c);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, 32'(bus.o_valid), 0);
        checkOutput({tag, "_data"},  32'(bus.o_data), 0);
        checkOutput({tag, "_row"},   32'(bus.o_row_cnt), 0);
        checkOutput({tag, "_col"},   32'(bus.o_col_cnt), 0);
        checkOutput({tag, "_sof"},   32'(bus.o_sof), 0);
        checkOutput({tag, "_stall"}, 32'(bus.o_stall_cnt), 0);
        checkOutput({tag, "_ready"}, 32'(bus.o_pl_ready), 0);
    endtask

    initial begin
        int seen;

        i_rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge i_clk);
        checkResetState("reset");
        i_rst = 1'b0;
        @(negedge i_clk);

        // Two frames: the first runs clean, the second carries the events.
        pushFrame(1'b0);
        pushFrame(1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitPos(3, 1040, "frame1_end");

        // Enable drop mid-frame: frame 2 must still run to completion.
        waitPos(1, 99, "f2_r1c99");
        applyStimulus(1'b0, 1'b1, 1'b0);

        // Underrun: 5 cycles with no payload, column held at 499.
        waitPos(1, 499, "f2_r1c499");
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            checkOutput("underrun_valid", 32'(bus.o_valid), 0);
            checkOutput("underrun_col_hold", 32'(bus.o_col_cnt), 499);
        end
        checkOutput("underrun_stall_cnt", 32'(bus.o_stall_cnt), 5);
        applyStimulus(1'b0, 1'b1, 1'b0);

        // Retrans in overhead: 3 idle cycles, overhead address parked on col 7.
        waitPos(2, 6, "f2_r2c6");
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            checkOutput("retrans_oh_valid", 32'(bus.o_valid), 0);
            checkOutput("retrans_oh_col", 32'(bus.o_oh_col), 7);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);

        // Retrans and underrun together: retrans wins, no stall counted.
        waitPos(2, 299, "f2_r2c299");
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            checkOutput("overlap_pl_ready", 32'(bus.o_pl_ready), 0);
        end
        checkOutput("overlap_stall_cnt", 32'(bus.o_stall_cnt), 5);
        applyStimulus(1'b0, 1'b1, 1'b0);

        waitPos(3, 1040, "frame2_end");
        checkOutput("sof_spacing", 32'(sof_t[1] - sof_t[0]), 4164);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (bus.o_valid) seen++;
        end
        checkOutput("idle_after_disable", 32'(seen), 0);
        checkOutput("idle_col_hold", 32'(bus.o_col_cnt), 1040);
        checkOutput("frame2_drained", 32'(exp_q.size()), 0);

        // Parity frame followed by a frame that gets reset mid-payload.
        pushFrame(1'b1);
        pushFrame(1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitPos(0, 1040, "f3_parity_r0");
        checkOutput("parity_row0", 32'(bus.o_data), 32'h55);
        waitPos(1, 1040, "f3_parity_r1");
        checkOutput("parity_row1_cleared", 32'(bus.o_data), 32'h00);

        waitPos(0, 200, "f4_r0c200");
        i_rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge i_clk);
        checkResetState("midreset");
        exp_q.delete();
        i_rst = 1'b0;
        @(negedge i_clk);
        pl_wr = pl_rd;

        // Restart after reset must begin with sof at row 0 col 0.
        pushFrame(1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitPos(0, 0, "restart_r0c0");
        checkOutput("restart_sof", 32'(bus.o_sof), 1);
        checkOutput("restart_data", 32'(bus.o_data), 32'hA0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitPos(3, 1040, "frame5_end");
        repeat (5) @(negedge i_clk);
        checkOutput("final_drained", 32'(exp_q.size()), 0);
        checkOutput("final_valid_low", 32'(bus.o_valid), 0);
        checkOutput("final_stall_cnt", 32'(bus.o_stall_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
